sat_chan_sched: RTL and testbench

//  Configuration scheduler for a bank of NUM_CHAN satellite channels. Host writes per-channel

---
 rtl/sat_chan_sched_if.sv | 22 ++
 rtl/sat_chan_sched.sv | 205 ++++++++++++++++++++
 tb/tb_sat_chan_sched.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sat_chan_sched_if.sv
// Host-side configuration port of the channel scheduler.
// Carries the write handshake, the commit pulse and the commit status flags.
interface sat_chan_sched_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_chan;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        commit;
    logic        commit_busy;
    logic        cfg_err;

    modport master (
        output cfg_valid, cfg_chan, cfg_addr, cfg_data, commit,
        input  cfg_ready, commit_busy, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_addr, cfg_data, commit,
        output cfg_ready, commit_busy, cfg_err
    );
endinterface

// File: rtl/sat_chan_sched.sv
// Staged/active configuration banks for NUM_CHAN satellite channels plus the shared sample strobe.
// A commit copies the whole staging bank into the active bank on a strobe edge, atomically.
module sat_chan_sched #(
    parameter int NUM_CHAN = 8,
    parameter int DIV      = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    sat_chan_sched_if.slave         host,
    output logic                    dv_out_o,
    output logic [15:0]             commit_count_o,
    output logic [NUM_CHAN-1:0]     chan_en_o,
    output logic [32*NUM_CHAN-1:0]  dop_freq_o,
    output logic [32*NUM_CHAN-1:0]  code_freq_o,
    output logic [16*NUM_CHAN-1:0]  gain_o,
    output logic [6*NUM_CHAN-1:0]   ca_sel_o
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                   state_q;
    logic                     cfg_ready_q;
    logic                     commit_busy_q;
    logic [15:0]              commit_count_q;

    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            cnt_d;
    logic                     dv_q;
    logic                     strobe_s;

    logic                     wr_acc_s;
    logic                     bad_chan_s;
    logic                     cfg_err_q;
    logic                     cfg_err_d;

    logic [32*NUM_CHAN-1:0]   stg_dop_q,  stg_dop_d;
    logic [32*NUM_CHAN-1:0]   stg_code_q, stg_code_d;
    logic [16*NUM_CHAN-1:0]   stg_gain_q, stg_gain_d;
    logic [6*NUM_CHAN-1:0]    stg_ca_q,   stg_ca_d;
    logic [NUM_CHAN-1:0]      stg_en_q,   stg_en_d;

    logic [32*NUM_CHAN-1:0]   act_dop_q;
    logic [32*NUM_CHAN-1:0]   act_code_q;
    logic [16*NUM_CHAN-1:0]   act_gain_q;
    logic [6*NUM_CHAN-1:0]    act_ca_q;
    logic [NUM_CHAN-1:0]      act_en_q;

    // The strobe fires on the last count of each DIV-cycle window.
    assign strobe_s   = (cnt_q == CNT_LAST);
    assign wr_acc_s   = host.cfg_valid & cfg_ready_q;
    assign bad_chan_s = ({1'b0, host.cfg_chan} >= 5'(NUM_CHAN));

    // Next strobe-counter value: wraps at DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (strobe_s) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Free-running strobe counter and registered sample strobe.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= {CW{1'b0}};
            dv_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dv_q  <= strobe_s;
        end
    end

    // Staging-bank next state: an accepted write to a valid channel updates one field.
    always_comb begin
        stg_dop_d  = stg_dop_q;
        stg_code_d = stg_code_q;
        stg_gain_d = stg_gain_q;
        stg_ca_d   = stg_ca_q;
        stg_en_d   = stg_en_q;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (wr_acc_s && (host.cfg_chan == 4'(i))) begin
                case (host.cfg_addr)
                    2'd0: stg_dop_d[32*i +: 32]  = host.cfg_data;
                    2'd1: stg_code_d[32*i +: 32] = host.cfg_data;
                    2'd2: begin
                        stg_gain_d[16*i +: 16] = host.cfg_data[15:0];
                        stg_ca_d[6*i +: 6]     = host.cfg_data[21:16];
                    end
                    2'd3: stg_en_d[i] = host.cfg_data[0];
                    default: stg_en_d[i] = stg_en_q[i];
                endcase
            end else begin
                stg_en_d[i] = stg_en_q[i];
            end
        end
    end

    // Out-of-range channel writes still complete the handshake but only raise the sticky error.
    always_comb begin
        cfg_err_d = cfg_err_q;
        if (wr_acc_s && bad_chan_s) begin
            cfg_err_d = 1'b1;
        end else begin
            cfg_err_d = cfg_err_q;
        end
    end

    // Staging bank and sticky error register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stg_dop_q  <= {(32*NUM_CHAN){1'b0}};
            stg_code_q <= {(32*NUM_CHAN){1'b0}};
            stg_gain_q <= {(16*NUM_CHAN){1'b0}};
            stg_ca_q   <= {(6*NUM_CHAN){1'b0}};
            stg_en_q   <= {NUM_CHAN{1'b0}};
            cfg_err_q  <= 1'b0;
        end else begin
            stg_dop_q  <= stg_dop_d;
            stg_code_q <= stg_code_d;
            stg_gain_q <= stg_gain_d;
            stg_ca_q   <= stg_ca_d;
            stg_en_q   <= stg_en_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Commit FSM: the apply edge coincides with the edge that raises dv_out.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            cfg_ready_q    <= 1'b1;
            commit_busy_q  <= 1'b0;
            commit_count_q <= 16'd0;
            act_dop_q      <= {(32*NUM_CHAN){1'b0}};
            act_code_q     <= {(32*NUM_CHAN){1'b0}};
            act_gain_q     <= {(16*NUM_CHAN){1'b0}};
            act_ca_q       <= {(6*NUM_CHAN){1'b0}};
            act_en_q       <= {NUM_CHAN{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (host.commit) begin
                        state_q       <= ST_PENDING;
                        cfg_ready_q   <= 1'b0;
                        commit_busy_q <= 1'b1;
                    end else begin
                        cfg_ready_q   <= 1'b1;
                        commit_busy_q <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (strobe_s) begin
                        act_dop_q      <= stg_dop_q;
                        act_code_q     <= stg_code_q;
                        act_gain_q     <= stg_gain_q;
                        act_ca_q       <= stg_ca_q;
                        act_en_q       <= stg_en_q;
                        commit_count_q <= commit_count_q + 16'd1;
                        state_q        <= ST_IDLE;
                        cfg_ready_q    <= 1'b1;
                        commit_busy_q  <= 1'b0;
                    end else begin
                        cfg_ready_q    <= 1'b0;
                        commit_busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    cfg_ready_q   <= 1'b1;
                    commit_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Disabled channels present zero gain regardless of the stored value.
    always_comb begin
        gain_o = {(16*NUM_CHAN){1'b0}};
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (act_en_q[i]) begin
                gain_o[16*i +: 16] = act_gain_q[16*i +: 16];
            end else begin
                gain_o[16*i +: 16] = 16'd0;
            end
        end
    end

    assign host.cfg_ready   = cfg_ready_q;
    assign host.commit_busy = commit_busy_q;
    assign host.cfg_err     = cfg_err_q;
    assign dv_out_o         = dv_q;
    assign commit_count_o   = commit_count_q;
    assign chan_en_o        = act_en_q;
    assign dop_freq_o       = act_dop_q;
    assign code_freq_o      = act_code_q;
    assign ca_sel_o         = act_ca_q;

endmodule

// File: tb/tb_sat_chan_sched.sv
// Self-checking bench for sat_chan_sched: directed scenarios with literal expectations
// plus randomized host traffic compared every cycle against a behavioural model.
module tb_sat_chan_sched;
    localparam int NC = 8;
    localparam int DV = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sat_chan_sched_if host_if ();

    logic              dv_out;
    logic [15:0]       commit_count;
    logic [NC-1:0]     chan_en;
    logic [32*NC-1:0]  dop_freq;
    logic [32*NC-1:0]  code_freq;
    logic [16*NC-1:0]  gain;
    logic [6*NC-1:0]   ca_sel;

    int errors = 0;
    int checks = 0;

    sat_chan_sched #(.NUM_CHAN(NC), .DIV(DV)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .host           (host_if),
        .dv_out_o       (dv_out),
        .commit_count_o (commit_count),
        .chan_en_o      (chan_en),
        .dop_freq_o     (dop_freq),
        .code_freq_o    (code_freq),
        .gain_o         (gain),
        .ca_sel_o       (ca_sel)
    );

    always #5 clk = ~clk;

    // Behavioural model: per-channel staging/active records, a pending flag and an edge count.
    logic [31:0] m_sdop [16];
    logic [31:0] m_scode[16];
    logic [15:0] m_sgain[16];
    logic [5:0]  m_sca  [16];
    logic        m_sen  [16];
    logic [31:0] m_adop [16];
    logic [31:0] m_acode[16];
    logic [15:0] m_again[16];
    logic [5:0]  m_aca  [16];
    logic        m_aen  [16];
    logic        m_pend;
    logic        m_err;
    logic        m_dv;
    logic [15:0] m_cnt;
    int          m_cyc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_sdop[i] <= 32'd0; m_scode[i] <= 32'd0; m_sgain[i] <= 16'd0; m_sca[i] <= 6'd0; m_sen[i] <= 1'b0;
                m_adop[i] <= 32'd0; m_acode[i] <= 32'd0; m_again[i] <= 16'd0; m_aca[i] <= 6'd0; m_aen[i] <= 1'b0;
            end
            m_pend <= 1'b0; m_err <= 1'b0; m_dv <= 1'b0; m_cnt <= 16'd0; m_cyc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            m_dv  <= (((m_cyc + 1) % DV) == 0);
            if (host_if.cfg_valid && !m_pend) begin
                if (int'(host_if.cfg_chan) < NC) begin
                    case (host_if.cfg_addr)
                        2'd0: m_sdop[host_if.cfg_chan]  <= host_if.cfg_data;
                        2'd1: m_scode[host_if.cfg_chan] <= host_if.cfg_data;
                        2'd2: begin
                            m_sgain[host_if.cfg_chan] <= host_if.cfg_data[15:0];
                            m_sca[host_if.cfg_chan]   <= host_if.cfg_data[21:16];
                        end
                        default: m_sen[host_if.cfg_chan] <= host_if.cfg_data[0];
                    endcase
                end else begin
                    m_err <= 1'b1;
                end
            end
            if (m_pend && (((m_cyc + 1) % DV) == 0)) begin
                m_adop <= m_sdop; m_acode <= m_scode; m_again <= m_sgain; m_aca <= m_sca; m_aen <= m_sen;
                m_cnt  <= m_cnt + 16'd1;
                m_pend <= 1'b0;
            end else if (!m_pend && host_if.commit) begin
                m_pend <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [32*NC-1:0] e_dop, e_code;
        logic [16*NC-1:0] e_gain;
        logic [6*NC-1:0]  e_ca;
        logic [NC-1:0]    e_en;
        for (int i = 0; i < NC; i++) begin
            e_dop[32*i +: 32]  = m_adop[i];
            e_code[32*i +: 32] = m_acode[i];
            e_gain[16*i +: 16] = m_aen[i] ? m_again[i] : 16'd0;
            e_ca[6*i +: 6]     = m_aca[i];
            e_en[i]            = m_aen[i];
        end
        chk("dv_out", 512'(dv_out), 512'(m_dv));
        chk("cfg_ready", 512'(host_if.cfg_ready), 512'(!m_pend));
        chk("commit_busy", 512'(host_if.commit_busy), 512'(m_pend));
        chk("cfg_err", 512'(host_if.cfg_err), 512'(m_err));
        chk("commit_count", 512'(commit_count), 512'(m_cnt));
        chk("chan_en", 512'(chan_en), 512'(e_en));
        chk("dop_freq", 512'(dop_freq), 512'(e_dop));
        chk("code_freq", 512'(code_freq), 512'(e_code));
        chk("gain", 512'(gain), 512'(e_gain));
        chk("ca_sel", 512'(ca_sel), 512'(e_ca));
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(posedge clk) begin
        #2;
        if (!reset) compare_all();
    end

    // Called at a negedge; returns at the negedge after the write was accepted.
    task automatic do_write(input logic [3:0] ch, input logic [1:0] a, input logic [31:0] d, input logic with_commit);
        int n = 0;
        host_if.cfg_valid = 1'b1;
        host_if.cfg_chan  = ch;
        host_if.cfg_addr  = a;
        host_if.cfg_data  = d;
        host_if.commit    = with_commit;
        while (!host_if.cfg_ready && n < 64) begin
            @(negedge clk);
            host_if.commit = 1'b0;
            n++;
        end
        if (n >= 64) chk("write_timeout", 512'(0), 512'(1));
        @(negedge clk);
        host_if.cfg_valid = 1'b0;
        host_if.commit    = 1'b0;
    endtask

    task automatic pulse_commit();
        host_if.commit = 1'b1;
        @(negedge clk);
        host_if.commit = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (host_if.commit_busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk("apply_timeout", 512'(0), 512'(1));
    endtask

    initial begin
        logic [32*NC-1:0] exp_dop;
        host_if.cfg_valid = 1'b0;
        host_if.cfg_chan  = 4'd0;
        host_if.cfg_addr  = 2'd0;
        host_if.cfg_data  = 32'd0;
        host_if.commit    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Strobe: high only after edges 4, 8, 12.
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            chk("strobe_phase", 512'(dv_out), 512'((k % 4) == 0));
        end
        @(negedge clk);
        chk("ready_after_reset", 512'(host_if.cfg_ready), 512'(1));

        // Atomic commit of channel 2.
        do_write(4'd2, 2'd0, 32'h0001_0000, 1'b0);
        do_write(4'd2, 2'd1, 32'h0432_1000, 1'b0);
        do_write(4'd2, 2'd2, 32'h0005_4000, 1'b0);
        do_write(4'd2, 2'd3, 32'h0000_0001, 1'b1);
        chk("pre_apply_en", 512'(chan_en), 512'(0));
        chk("pre_apply_busy", 512'(host_if.commit_busy), 512'(1));
        wait_idle();
        chk("apply_with_dv", 512'(dv_out), 512'(1));
        chk("ch2_dop", 512'(dop_freq[64 +: 32]), 512'(32'h0001_0000));
        chk("ch2_code", 512'(code_freq[64 +: 32]), 512'(32'h0432_1000));
        chk("ch2_gain", 512'(gain[32 +: 16]), 512'(16'h4000));
        chk("ch2_ca", 512'(ca_sel[12 +: 6]), 512'(6'h05));
        chk("ch2_en", 512'(chan_en), 512'(8'h04));
        chk("count_1", 512'(commit_count), 512'(16'd1));

        // Backpressure and ignored second commit.
        pulse_commit();
        chk("ready_low_pending", 512'(host_if.cfg_ready), 512'(0));
        do_write(4'd3, 2'd0, 32'hDEAD_BEEF, 1'b1);
        chk("count_once", 512'(commit_count), 512'(16'd2));
        chk("ch3_not_active", 512'(dop_freq[96 +: 32]), 512'(0));
        pulse_commit();
        wait_idle();
        chk("ch3_active", 512'(dop_freq[96 +: 32]), 512'(32'hDEAD_BEEF));
        chk("count_3", 512'(commit_count), 512'(16'd3));

        // Write and commit in the same cycle.
        do_write(4'd0, 2'd3, 32'h0000_0001, 1'b0);
        do_write(4'd0, 2'd2, 32'h0000_1234, 1'b1);
        wait_idle();
        chk("same_cycle_gain0", 512'(gain[15:0]), 512'(16'h1234));
        chk("count_4", 512'(commit_count), 512'(16'd4));

        // Out-of-range channel.
        chk("err_clear", 512'(host_if.cfg_err), 512'(0));
        do_write(4'd9, 2'd0, 32'hFFFF_FFFF, 1'b0);
        chk("err_set", 512'(host_if.cfg_err), 512'(1));
        pulse_commit();
        wait_idle();
        exp_dop = '0;
        exp_dop[64 +: 32] = 32'h0001_0000;
        exp_dop[96 +: 32] = 32'hDEAD_BEEF;
        chk("bad_chan_no_change", 512'(dop_freq), 512'(exp_dop));
        chk("err_sticky", 512'(host_if.cfg_err), 512'(1));

        // Gain gated by a disabled channel.
        do_write(4'd1, 2'd2, 32'h0000_7FFF, 1'b0);
        do_write(4'd1, 2'd3, 32'h0000_0000, 1'b1);
        wait_idle();
        chk("gain1_gated", 512'(gain[16 +: 16]), 512'(0));
        chk("ch1_disabled", 512'(chan_en[1]), 512'(0));
        chk("count_6", 512'(commit_count), 512'(16'd6));

        // Random traffic against the model.
        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                do_write(4'($urandom_range(0, 9)), 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
            end else if (r < 8) begin
                pulse_commit();
            end else begin
                @(negedge clk);
            end
        end
        wait_idle();

        // Reset while a commit is pending.
        pulse_commit();
        chk("busy_before_reset", 512'(host_if.commit_busy), 512'(1));
        reset = 1'b1;
        #1;
        chk("rst_busy", 512'(host_if.commit_busy), 512'(0));
        chk("rst_en", 512'(chan_en), 512'(0));
        chk("rst_dop", 512'(dop_freq), 512'(0));
        chk("rst_gain", 512'(gain), 512'(0));
        chk("rst_count", 512'(commit_count), 512'(0));
        chk("rst_err", 512'(host_if.cfg_err), 512'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_apply_after_reset", 512'(commit_count), 512'(0));
        chk("no_apply_en", 512'(chan_en), 512'(0));
        chk("no_apply_code", 512'(code_freq), 512'(0));
        chk("idle_after_reset", 512'(host_if.commit_busy), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
